// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state type for the main-memory line responder.
//   LINE_W  : cache line width in bits
//   LADDR_W : line address width in bits
//   state_e : responder FSM states
package mem_pkg;
   localparam int LINE_W  = 128;
   localparam int LADDR_W = 26;
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK} state_e;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: NUM_LINES x LINE_W line storage with one sync write and one sync read port
module mem_line_array
  import mem_pkg::*;
#(
  parameter int NUM_LINES = 1024,
  parameter     INIT_FILE = "",
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [NUM_LINES];
  initial for (int i = 0; i < NUM_LINES; i++) mem[i] = '0;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) rdata <= reset ? '0 : re ? mem[raddr] : rdata;
endmodule

// File: rtl/main_memory_model.sv
// main_memory_model: fixed-latency line read / writeback responder behind the data cache.
//   clk, reset                         : clock, sync active-high reset
//   reqD_mem, reqAddrD_mem             : line read request and line address
//   reqD_cache_write, reqAddrD_write_mem, data_to_mem : line writeback request, address, data
//   data_from_mem                      : read line, valid in the ready cycle and held after
//   read_ready_from_mem                : one-cycle read-complete pulse
//   written_data_ack_from_mem          : one-cycle write-complete pulse
module main_memory_model
   import mem_pkg::*;
#(
   parameter int NUM_LINES   = 1024,
   parameter int MEM_LATENCY = 5,
   parameter     INIT_FILE   = ""
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               reqD_mem,
   input  logic [LADDR_W-1:0] reqAddrD_mem,
   input  logic               reqD_cache_write,
   input  logic [LADDR_W-1:0] reqAddrD_write_mem,
   input  logic [LINE_W-1:0]  data_to_mem,
   output logic [LINE_W-1:0]  data_from_mem,
   output logic               read_ready_from_mem,
   output logic               written_data_ack_from_mem
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(MEM_LATENCY - 1);
   // With a latency of one the wait phase vanishes and acceptance goes straight to the response.
   localparam state_e RD_FIRST = (MEM_LATENCY == 1) ? RD_RESP : RD_WAIT;
   localparam state_e WR_FIRST = (MEM_LATENCY == 1) ? WR_ACK : WR_WAIT;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              rd_pulse_q, rd_pulse_d;
   logic              wr_pulse_q, wr_pulse_d;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{reqAddrD_mem[LADDR_W-1:IDX_W], reqAddrD_write_mem[LADDR_W-1:IDX_W]};

   // Writeback wins over a simultaneous read so a refill sees the just-evicted line.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (reqD_cache_write) begin
               state_d = WR_FIRST;
               cnt_d   = LOAD;
               idx_d   = reqAddrD_write_mem[IDX_W-1:0];
               wdata_d = data_to_mem;
            end else if (reqD_mem) begin
               state_d = RD_FIRST;
               cnt_d   = LOAD;
               idx_d   = reqAddrD_mem[IDX_W-1:0];
            end
         end
         RD_WAIT: begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == 1) ? RD_RESP : RD_WAIT;
         end
         WR_WAIT: begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == 1) ? WR_ACK : WR_WAIT;
         end
         default: state_d = IDLE;
      endcase
      rd_pulse_d = (state_d == RD_RESP);
      wr_pulse_d = (state_d == WR_ACK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_pulse_q <= 1'b0;
         wr_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_pulse_q <= rd_pulse_d;
         wr_pulse_q <= wr_pulse_d;
      end
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   // The array read is launched one edge early so the line is registered in the ready cycle;
   // for a one-cycle latency that edge is the acceptance edge, before idx_q is loaded.
   mem_line_array #(.NUM_LINES(NUM_LINES), .INIT_FILE(INIT_FILE)) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (state_q == WR_ACK),
      .waddr (idx_q),
      .wdata (wdata_q),
      .re    (rd_pulse_d),
      .raddr ((state_q == IDLE) ? reqAddrD_mem[IDX_W-1:0] : idx_q),
      .rdata (data_from_mem)
   );

   assign read_ready_from_mem       = rd_pulse_q;
   assign written_data_ack_from_mem = wr_pulse_q;
endmodule

// File: tb/tb_main_memory_model.sv
// tb_main_memory_model: randomized scoreboard bench for main_memory_model.
module tb_main_memory_model;
   localparam int L = 5;
   localparam int N = 1024;
   typedef struct {
      int           cyc;
      logic [127:0] d;
   } exp_t;

   logic         clk = 0, reset = 1, rq = 0, wq = 0;
   logic [25:0]  raddr = '0, waddr = '0;
   logic [127:0] wdata = '0, rdata;
   logic         rdy, ack;
   int           cyc = 0, tests = 0, fails = 0;
   bit           done = 0, rst_seen = 0;
   logic [127:0] hold = '0;
   logic [127:0] model [N];
   exp_t         rd_q[$], wr_q[$];

   main_memory_model #(.NUM_LINES(N), .MEM_LATENCY(L), .INIT_FILE("")) dut (
      .clk                       (clk),
      .reset                     (reset),
      .reqD_mem                  (rq),
      .reqAddrD_mem              (raddr),
      .reqD_cache_write          (wq),
      .reqAddrD_write_mem        (waddr),
      .data_to_mem               (wdata),
      .data_from_mem             (rdata),
      .read_ready_from_mem       (rdy),
      .written_data_ack_from_mem (ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT pulses, and polices timing and held data.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_seen) begin
         chk("rst_data", rdata, '0);
         chk("rst_ready", rdy, 0);
         chk("rst_ack", ack, 0);
         hold = '0;
      end else begin
         if (rdy) begin
            if (rd_q.size() == 0) chk("rd_unexpected", rdy, 0);
            else begin
               e = rd_q.pop_front();
               chk("rd_cycle", e.cyc, cyc);
               chk("rd_data", rdata, e.d);
               hold = e.d;
            end
         end else chk("rd_hold", rdata, hold);
         if (ack) begin
            if (wr_q.size() == 0) chk("wr_unexpected", ack, 0);
            else begin
               e = wr_q.pop_front();
               chk("wr_cycle", e.cyc, cyc);
            end
         end
         if (rd_q.size() != 0 && cyc > rd_q[0].cyc) begin
            e = rd_q.pop_front();
            chk("rd_timeout", rdy, 1);
         end
         if (wr_q.size() != 0 && cyc > wr_q[0].cyc) begin
            e = wr_q.pop_front();
            chk("wr_timeout", ack, 1);
         end
      end
      if (done) begin
         chk("rd_pending", rd_q.size(), 0);
         chk("wr_pending", wr_q.size(), 0);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   task automatic wait_pulse(input bit w);
      for (int i = 0; i < 4 * L + 8; i++) begin
         @(negedge clk);
         if (w ? ack : rdy) break;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit w, input int c, input logic [127:0] d);
      exp_t e;
      e.cyc = c;
      e.d   = d;
      if (w) wr_q.push_back(e);
      else   rd_q.push_back(e);
   endtask

   task automatic do_read(input logic [25:0] a, input bit chg);
      rq = 1;
      raddr = a;
      push(0, cyc + L, model[a[9:0]]);
      if (chg) begin
         repeat (2) @(posedge clk);
         #1 raddr = 26'($urandom);
      end
      wait_pulse(0);
      rq = 0;
   endtask

   task automatic do_write(input logic [25:0] a, input logic [127:0] d, input bit chg);
      wq = 1;
      waddr = a;
      wdata = d;
      push(1, cyc + L, d);
      model[a[9:0]] = d;
      if (chg) begin
         repeat (2) @(posedge clk);
         #1 waddr = 26'($urandom);
         wdata = ~d;
      end
      wait_pulse(1);
      wq = 0;
   endtask

   task automatic do_both(input logic [25:0] wa, input logic [25:0] ra, input logic [127:0] d);
      int k;
      k = cyc;
      wq = 1;
      rq = 1;
      waddr = wa;
      raddr = ra;
      wdata = d;
      push(1, k + L, d);
      model[wa[9:0]] = d;
      push(0, k + 2 * L + 1, model[ra[9:0]]);
      wait_pulse(1);
      wq = 0;
      wait_pulse(0);
      rq = 0;
   endtask

   task automatic do_rst_write(input logic [25:0] a, input logic [127:0] d);
      wq = 1;
      waddr = a;
      wdata = d;
      repeat (2) @(posedge clk);
      #1 reset = 1;
      wq = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      for (int i = 0; i < N; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      do_read(26'h3, 0);
      do_write(26'h2, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 0);
      do_read(26'h2, 0);
      do_write(26'h7, 128'h11112222_33334444_55556666_77778888, 0);
      do_read(26'h7, 0);
      do_both(26'h9, 26'h9, {128{1'b1}});
      do_rst_write(26'h7, 128'hDEAD);
      do_read(26'h7, 0);
      do_write(26'h0, 128'h0123_4567_89AB_CDEF, 0);
      do_read(26'h400, 0);
      do_read(26'h2, 1);
      do_write(26'h5, 128'h5555, 1);
      do_read(26'h5, 0);
      for (int n = 0; n < 40; n++) begin
         logic [25:0] a, b;
         a = {16'($urandom), 10'($urandom_range(0, 15))};
         b = {16'($urandom), 10'($urandom_range(0, 15))};
         case ($urandom_range(0, 4))
            0: do_read(a, 0);
            1: do_write(a, rnd_line(), 0);
            2: do_both(a, b, rnd_line());
            3: do_read(a, 1);
            default: do_write(a, rnd_line(), 1);
         endcase
      end
      repeat (3) @(posedge clk);
      done = 1;
   end
endmodule
